// File: rtl/tl_pkg.sv
// TileLink shared definitions: channel opcodes, E-channel payload and a
// helper for GrantData beat counting.
package tl_pkg;

    localparam logic [2:0] ACCESSACKDATA = 3'd1;
    localparam logic [2:0] GRANT         = 3'd4;
    localparam logic [2:0] GRANTDATA     = 3'd5;

    // Widest sink id any node may use; narrower sinks are zero-extended.
    localparam int TL_SINK_MAX_W = 8;

    // Beat counter width: 2^15 bytes at 1 byte/beat still fits.
    localparam int TL_BEAT_W = 16;

    typedef struct packed {
        logic [TL_SINK_MAX_W-1:0] sink;
    } tl_e_t;

    // Index of the last beat of a data message: max(1, 2^size/bytes) - 1.
    function automatic logic [TL_BEAT_W-1:0] last_beat_idx(input logic [3:0] size,
                                                            input int lg_bytes);
        if (int'(size) > lg_bytes)
            return TL_BEAT_W'((32'd1 << (int'(size) - lg_bytes)) - 32'd1);
        return '0;
    endfunction

endpackage

// File: rtl/tl_sink_fifo.sv
// Small FIFO of sink ids. Pointers wrap naturally (DEPTH is a power of two);
// the extra count bit separates full from empty.
module tl_sink_fifo #(
    parameter int DEPTH  = 4,
    parameter int SINK_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [SINK_W-1:0] din_i,
    input  logic              pop_i,
    output logic [SINK_W-1:0] dout_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int PW = $clog2(DEPTH);

    logic [SINK_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;
    logic              do_push, do_pop;

    assign empty_o = (count == '0);
    assign full_o  = (count == (PW+1)'(DEPTH));
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem[rd_ptr];

    // Pointer and occupancy tracking; simultaneous push/pop leaves count alone.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din_i;
    end

endmodule

// File: rtl/tl_grant_ack_gen.sv
// Watches D-channel Grant/GrantData traffic and queues a GrantAck (E beat)
// for each completed message. D is only stalled on the last beat of a Grant
// when the ack queue is already full, so no ack is ever dropped.
module tl_grant_ack_gen
    import tl_pkg::*;
#(
    parameter int SINK_W     = 3,
    parameter int DATA_BYTES = 8,
    parameter int DEPTH      = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              d_valid_i,
    output logic              d_ready_o,
    input  logic [2:0]        d_opcode_i,
    input  logic [3:0]        d_size_i,
    input  logic [SINK_W-1:0] d_sink_i,
    output logic              d_valid_o,
    input  logic              d_ready_i,
    output logic              e_valid_o,
    input  logic              e_ready_i,
    output tl_e_t             e_bits_o
);

    localparam int LG_DB = $clog2(DATA_BYTES);

    logic [TL_BEAT_W-1:0] beat_cnt;
    logic [TL_BEAT_W-1:0] last_idx;
    logic                 is_grant, is_gdata, is_last, stall;
    logic                 d_fire, e_fire, push;
    logic                 q_empty, q_full;
    logic [SINK_W-1:0]    q_head;

    assign is_gdata = (d_opcode_i == GRANTDATA);
    assign is_grant = (d_opcode_i == GRANT) | is_gdata;
    assign last_idx = is_gdata ? last_beat_idx(d_size_i, LG_DB) : '0;
    assign is_last  = (d_opcode_i == GRANT) | (beat_cnt == last_idx);

    // Stall uses the registered full flag only; a same-cycle pop does not help.
    assign stall     = q_full & is_grant & is_last;
    assign d_ready_o = d_ready_i & ~stall;
    assign d_valid_o = d_valid_i & ~stall;

    assign d_fire = d_valid_i & d_ready_o;
    assign e_fire = e_valid_o & e_ready_i;
    assign push   = d_fire & is_grant & is_last;

    // Beat position within a GrantData burst; wraps to 0 after the last beat.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            beat_cnt <= '0;
        else if (d_fire && is_gdata)
            beat_cnt <= is_last ? '0 : beat_cnt + 1'b1;
    end

    tl_sink_fifo #(
        .DEPTH  (DEPTH),
        .SINK_W (SINK_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .din_i   (d_sink_i),
        .pop_i   (e_fire),
        .dout_o  (q_head),
        .empty_o (q_empty),
        .full_o  (q_full)
    );

    assign e_valid_o = ~q_empty;

    // E payload: only sink is meaningful, the rest stays zero.
    always_comb begin
        e_bits_o      = '0;
        e_bits_o.sink = TL_SINK_MAX_W'(q_head);
    end

endmodule

// File: tb/tb_tl_grant_ack_gen.sv
// Directed bench for tl_grant_ack_gen (SINK_W=3, DATA_BYTES=8, DEPTH=4).
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_tl_grant_ack_gen;
    import tl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       d_valid_i, d_ready_i, e_ready_i;
    logic [2:0] d_opcode_i;
    logic [3:0] d_size_i;
    logic [2:0] d_sink_i;
    logic       d_ready_o, d_valid_o, e_valid_o;
    tl_e_t      e_bits_o;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    tl_grant_ack_gen #(.SINK_W(3), .DATA_BYTES(8), .DEPTH(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .d_valid_i  (d_valid_i),
        .d_ready_o  (d_ready_o),
        .d_opcode_i (d_opcode_i),
        .d_size_i   (d_size_i),
        .d_sink_i   (d_sink_i),
        .d_valid_o  (d_valid_o),
        .d_ready_i  (d_ready_i),
        .e_valid_o  (e_valid_o),
        .e_ready_i  (e_ready_i),
        .e_bits_o   (e_bits_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock: to the next falling edge, then settle.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] sz,
                         input logic [2:0] sk);
        d_valid_i  = v;
        d_opcode_i = op;
        d_size_i   = sz;
        d_sink_i   = sk;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] msg [10];
        rst_n = 1'b0; d_ready_i = 1'b1; e_ready_i = 1'b1;
        drive(1'b0, 3'd0, 4'd0, 3'd0);
        step(); step();
        chk("rst_e_valid", 32'(e_valid_o), 0);
        chk("rst_d_ready", 32'(d_ready_o), 1);
        @(negedge clk); rst_n = 1'b1;

        // Single GRANT: ack exactly one cycle after the D fire.
        drive(1'b1, GRANT, 4'd0, 3'd5);
        chk("g1_d_ready", 32'(d_ready_o), 1);
        chk("g1_e_before", 32'(e_valid_o), 0);
        step(); drive(1'b0, GRANT, 4'd0, 3'd0);
        chk("g1_e_valid", 32'(e_valid_o), 1);
        chk("g1_e_sink", 32'(e_bits_o.sink), 5);
        step();
        chk("g1_empty", 32'(e_valid_o), 0);

        // GRANTDATA size 6 -> 8 beats, ack only after the 8th.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, GRANTDATA, 4'd6, 3'd3);
            chk($sformatf("gd8_beat%0d_no_e", i), 32'(e_valid_o), 0);
            step();
        end
        drive(1'b0, GRANTDATA, 4'd6, 3'd0);
        chk("gd8_e_valid", 32'(e_valid_o), 1);
        chk("gd8_e_sink", 32'(e_bits_o.sink), 3);
        step();
        chk("gd8_empty", 32'(e_valid_o), 0);

        // GRANTDATA smaller than one beat counts as a single beat.
        drive(1'b1, GRANTDATA, 4'd2, 3'd6);
        step(); drive(1'b0, GRANTDATA, 4'd2, 3'd0);
        chk("gd1_e_sink", 32'(e_bits_o.sink), 6);
        chk("gd1_e_valid", 32'(e_valid_o), 1);
        step();

        // Fill queue with e_ready low, then stall the fifth ack.
        e_ready_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, GRANT, 4'd0, 3'(k));
            step();
        end
        drive(1'b1, ACCESSACKDATA, 4'd3, 3'd0);
        chk("full_nongrant_ready", 32'(d_ready_o), 1);
        drive(1'b1, GRANT, 4'd0, 3'd5);
        chk("full_d_ready", 32'(d_ready_o), 0);
        chk("full_d_valid", 32'(d_valid_o), 0);
        chk("full_head", 32'(e_bits_o.sink), 1);
        step();
        chk("full_head_stable", 32'(e_bits_o.sink), 1);
        e_ready_i = 1'b1; #1;
        chk("full_same_cycle_pop_still_stalled", 32'(d_ready_o), 0);
        step();
        chk("drain_head2", 32'(e_bits_o.sink), 2);
        chk("drain_d_ready", 32'(d_ready_o), 1);
        step(); drive(1'b0, GRANT, 4'd0, 3'd0);
        for (int k = 3; k <= 5; k++) begin
            chk($sformatf("drain_valid%0d", k), 32'(e_valid_o), 1);
            chk($sformatf("drain_sink%0d", k), 32'(e_bits_o.sink), k);
            step();
        end
        chk("drain_empty", 32'(e_valid_o), 0);

        // Steady push+pop at count 2 across pointer wrap.
        for (int k = 0; k < 10; k++) msg[k] = 3'((k * 3 + 1) % 8);
        e_ready_i = 1'b0;
        for (int j = 0; j < 12; j++) begin
            if (j < 10) drive(1'b1, GRANT, 4'd0, msg[j]);
            else        drive(1'b0, GRANT, 4'd0, 3'd0);
            if (j == 2) begin e_ready_i = 1'b1; #1; end
            if (j >= 2) begin
                chk($sformatf("wrap_valid%0d", j), 32'(e_valid_o), 1);
                chk($sformatf("wrap_sink%0d", j), 32'(e_bits_o.sink), 32'(msg[j-2]));
            end
            step();
        end
        chk("wrap_empty", 32'(e_valid_o), 0);

        // ACCESSACKDATA passes through, never generates an ack.
        for (int i = 0; i < 3; i++) begin
            d_ready_i = (i != 1);
            drive(1'b1, ACCESSACKDATA, 4'd6, 3'd2);
            chk($sformatf("aad_ready%0d", i), 32'(d_ready_o), 32'(d_ready_i));
            chk($sformatf("aad_valid%0d", i), 32'(d_valid_o), 1);
            step();
        end
        d_ready_i = 1'b1;
        drive(1'b0, ACCESSACKDATA, 4'd6, 3'd0);
        chk("aad_no_e", 32'(e_valid_o), 0);

        // Reset mid-operation: 2 acks queued, GRANTDATA at beat 3 of 8.
        e_ready_i = 1'b0;
        drive(1'b1, GRANT, 4'd0, 3'd6); step();
        drive(1'b1, GRANT, 4'd0, 3'd7); step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, GRANTDATA, 4'd6, 3'd1);
            step();
        end
        drive(1'b0, GRANT, 4'd0, 3'd0);
        chk("pre_rst_e_valid", 32'(e_valid_o), 1);
        rst_n = 1'b0; #1;
        chk("rst_async_e_valid", 32'(e_valid_o), 0);
        step();
        rst_n = 1'b1; e_ready_i = 1'b1;
        drive(1'b1, GRANT, 4'd0, 3'd2);
        step(); drive(1'b0, GRANT, 4'd0, 3'd0);
        chk("post_rst_e_valid", 32'(e_valid_o), 1);
        chk("post_rst_e_sink", 32'(e_bits_o.sink), 2);
        step();
        chk("post_rst_single", 32'(e_valid_o), 0);

        // Beat counter restarted: a 2-beat GRANTDATA acks after beat 2.
        drive(1'b1, GRANTDATA, 4'd4, 3'd3); step();
        chk("gd2_after_beat1", 32'(e_valid_o), 0);
        step(); drive(1'b0, GRANTDATA, 4'd4, 3'd0);
        chk("gd2_after_beat2", 32'(e_valid_o), 1);
        chk("gd2_sink", 32'(e_bits_o.sink), 3);
        step();
        chk("gd2_empty", 32'(e_valid_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
